// File: rtl/ftoi_wb_buffer_pkg.sv
// rtl/ftoi_wb_buffer_pkg.sv - shared types for the ftoi writeback buffer
package fpu_wb_pkg;

  localparam int TAG_W = 5;

  typedef struct packed {
    logic [TAG_W-1:0] rd;
    logic [31:0]      data;
  } wb_entry_t;

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] rd;
  } tag_stage_t;

endpackage

// File: rtl/ftoi_wb_buffer_if.sv
// rtl/ftoi_wb_buffer_if.sv - integer writeback valid/ready bus
interface ftoi_wb_buffer_if import fpu_wb_pkg::*; ();

  logic             wb_valid;
  logic [TAG_W-1:0] wb_rd;
  logic [31:0]      wb_data;
  logic             wb_ready;

  modport master (output wb_valid, wb_rd, wb_data, input wb_ready);
  modport slave  (input wb_valid, wb_rd, wb_data, output wb_ready);

endinterface

// File: rtl/ftoi_wb_buffer_fifo.sv
// rtl/ftoi_wb_buffer_fifo.sv - result queue with registered storage and clear
module wb_fifo import fpu_wb_pkg::*; #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rstn,
  input  logic   clear,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_MAX = DEPTH;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  // Storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ftoi_wb_buffer.sv
// rtl/ftoi_wb_buffer.sv - tags ftoi results, queues them and meters issue credits
module ftoi_wb_buffer import fpu_wb_pkg::*; #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             issue_valid,
  input  logic [TAG_W-1:0] issue_rd,
  output logic             issue_ready,
  input  logic             ftoi_valid,
  input  logic [31:0]      ftoi_y,
  input  logic             flush,
  ftoi_wb_buffer_if.master wb,
  output logic             err_align,
  output logic             err_ovf
);

  localparam int OUT_W = $clog2(DEPTH + 1);
  localparam int SH_W  = $clog2(LATENCY + 1);
  localparam logic [OUT_W-1:0] OUT_ONE = 1;
  localparam logic [OUT_W-1:0] OUT_MAX = DEPTH;
  localparam logic [SH_W-1:0]  SH_ONE  = 1;
  localparam logic [SH_W-1:0]  SH_LAT  = LATENCY;

  tag_stage_t       pipe [LATENCY];
  tag_stage_t       arrive;
  wb_entry_t        din;
  wb_entry_t        head;
  logic [OUT_W-1:0] outstanding;
  logic [SH_W-1:0]  shadow;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;

  assign arrive      = pipe[LATENCY-1];
  assign din         = '{rd: arrive.rd, data: ftoi_y};
  assign issue_ready = (outstanding < OUT_MAX);
  assign pop         = !empty && wb.wb_ready && !flush;
  assign push        = arrive.v && ftoi_valid && !flush && (!full || pop);
  assign drop        = arrive.v && ftoi_valid && full && !pop;

  assign wb.wb_valid = !empty;
  assign wb.wb_rd    = head.rd;
  assign wb.wb_data  = head.data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{v: issue_valid, rd: issue_rd};
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  // The shadow covers ftoi_valid pulses from conversions issued before a flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding <= '0;
      shadow      <= '0;
      err_align   <= 1'b0;
      err_ovf     <= 1'b0;
    end else if (flush) begin
      outstanding <= '0;
      shadow      <= SH_LAT;
    end else begin
      if (shadow != '0) shadow <= shadow - SH_ONE;
      if (issue_valid && !pop) begin
        if (outstanding != OUT_MAX) outstanding <= outstanding + OUT_ONE;
      end else if (!issue_valid && pop) begin
        outstanding <= outstanding - OUT_ONE;
      end
      if ((arrive.v ^ ftoi_valid) && (shadow == '0)) err_align <= 1'b1;
      if ((issue_valid && !issue_ready) || drop) err_ovf <= 1'b1;
    end
  end

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (wb_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_ftoi_wb_buffer.sv
// tb/tb_ftoi_wb_buffer.sv - self-checking bench for ftoi_wb_buffer
module tb_ftoi_wb_buffer;

  localparam int L = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        ftoi_valid;
  logic [31:0] ftoi_y;
  logic        flush;
  logic        err_align;
  logic        err_ovf;

  ftoi_wb_buffer_if wb_if ();

  ftoi_wb_buffer #(.LATENCY(L), .DEPTH(D)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .ftoi_valid  (ftoi_valid),
    .ftoi_y      (ftoi_y),
    .flush       (flush),
    .wb          (wb_if),
    .err_align   (err_align),
    .err_ovf     (err_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: in-flight tags with due edge, result queue, credits, flags.
  typedef struct { int due; logic [4:0] rd; } fl_t;
  fl_t         infl[$];
  logic [36:0] q_m[$];
  int          m_out      = 0;
  int          edge_n     = 0;
  int          last_flush = -100;
  logic        m_ea       = 1'b0;
  logic        m_eo       = 1'b0;
  logic        sv [L];
  logic [31:0] sy [L];

  task automatic model_reset();
    infl.delete();
    q_m.delete();
    m_out = 0;
    last_flush = -100;
    m_ea = 1'b0;
    m_eo = 1'b0;
    for (int i = 0; i < L; i++) begin sv[i] = 1'b0; sy[i] = '0; end
  endtask

  // Drives one cycle (including the ftoi stub), advances the model, ends at posedge+1.
  task automatic cycle(input logic iv, input logic [4:0] rd, input logic [31:0] y,
                       input logic wr, input logic fl, input logic inj);
    logic fv, tag, pop;
    logic [4:0] trd;
    fv = inj | sv[L-1];
    issue_valid = iv; issue_rd = rd; wb_if.wb_ready = wr; flush = fl;
    ftoi_valid = fv; ftoi_y = inj ? y : sy[L-1];
    pop = (q_m.size() != 0) && wr;
    if (fl) begin
      q_m.delete(); infl.delete(); m_out = 0; last_flush = edge_n;
    end else begin
      tag = 1'b0; trd = '0;
      if (infl.size() != 0 && infl[0].due == edge_n) begin
        tag = 1'b1; trd = infl[0].rd; infl.delete(0);
      end
      if ((tag ^ fv) && (edge_n - last_flush > L)) m_ea = 1'b1;
      if (iv && m_out >= D) m_eo = 1'b1;
      if (pop) q_m.delete(0);
      if (tag && fv) begin
        if (q_m.size() < D) q_m.push_back({trd, ftoi_y});
        else m_eo = 1'b1;
      end
      if (iv && !pop) m_out = (m_out < D) ? m_out + 1 : D;
      else if (!iv && pop) m_out = m_out - 1;
      if (iv) infl.push_back('{due: edge_n + L, rd: rd});
    end
    for (int i = L - 1; i > 0; i--) begin sv[i] = sv[i-1]; sy[i] = sy[i-1]; end
    sv[0] = iv; sy[0] = y;
    edge_n++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic wr);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, $urandom, wr, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0; ftoi_valid = 1'b0; ftoi_y = '0;
    wb_if.wb_ready = 1'b0;
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (wb_if.wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %0b want 0", wb_if.wb_valid); end
    n_checks++; if (wb_if.wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb_rd got %0d want 0", wb_if.wb_rd); end
    n_checks++; if (wb_if.wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_wb_data got %h want 0", wb_if.wb_data); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got %0b want 1", issue_ready); end
    n_checks++; if ({err_align, err_ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got %b want 00", {err_align, err_ovf}); end
  endtask

  task automatic test_single();
    logic [2:0] seen;
    cycle(1'b1, 5'd3, 32'h0000_07D1, 1'b0, 1'b0, 1'b0);
    seen[0] = wb_if.wb_valid;
    idle(1, 1'b0);
    seen[1] = wb_if.wb_valid;
    idle(1, 1'b0);
    seen[2] = wb_if.wb_valid;
    n_checks++; if (seen !== 3'b100) begin n_fail++; $display("FAIL single_latency got %b want 100", seen); end
    n_checks++; if (wb_if.wb_rd !== 5'd3 || wb_if.wb_data !== 32'h7D1) begin
      n_fail++; $display("FAIL single_head got rd=%0d data=%h want rd=3 data=7d1", wb_if.wb_rd, wb_if.wb_data); end
    idle(1, 1'b1);
    n_checks++; if (wb_if.wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_drain got valid=%0b ready=%0b want 0 1", wb_if.wb_valid, issue_ready); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 5'(i), $urandom, 1'b0, 1'b0, 1'b0);
      n_checks++; if (issue_ready !== (i < 4)) begin
        n_fail++; $display("FAIL b2b_ready_after_%0d got %0b want %0b", i, issue_ready, (i < 4)); end
    end
    idle(2, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (wb_if.wb_valid !== 1'b1 || wb_if.wb_rd !== 5'(i) || wb_if.wb_data !== q_m[0][31:0]) begin
        n_fail++; $display("FAIL b2b_pop_%0d got v=%0b rd=%0d data=%h want v=1 rd=%0d data=%h",
                           i, wb_if.wb_valid, wb_if.wb_rd, wb_if.wb_data, i, q_m[0][31:0]); end
      cycle(1'b0, 5'd0, $urandom, 1'b1, 1'b0, 1'b0);
      if (i == 1) begin
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_pop got %0b want 1", issue_ready); end
      end
    end
    n_checks++; if (wb_if.wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %0b want 0", wb_if.wb_valid); end
  endtask

  task automatic test_full_pop_issue();
    for (int i = 10; i <= 13; i++) cycle(1'b1, 5'(i), $urandom, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    cycle(1'b1, 5'd14, $urandom, 1'b1, 1'b0, 1'b0);
    n_checks++; if (issue_ready !== 1'b0 || m_out != D) begin
      n_fail++; $display("FAIL fpi_ready got %0b want 0", issue_ready); end
    n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL fpi_err_ovf got %0b want 1", err_ovf); end
    idle(2, 1'b0);
    for (int i = 11; i <= 14; i++) begin
      n_checks++; if (wb_if.wb_valid !== 1'b1 || wb_if.wb_rd !== 5'(i)) begin
        n_fail++; $display("FAIL fpi_order got v=%0b rd=%0d want v=1 rd=%0d", wb_if.wb_valid, wb_if.wb_rd, i); end
      cycle(1'b0, 5'd0, $urandom, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_alternating();
    logic [4:0] got[$];
    logic [4:0] want[5];
    logic [6:0] pat;
    pat = 7'b1101011;
    want = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd7};
    for (int n = 1; n <= 11; n++) begin
      if (wb_if.wb_valid === 1'b1) got.push_back(wb_if.wb_rd);
      cycle((n <= 7) ? pat[7-n] : 1'b0, 5'(n), $urandom, 1'b1, 1'b0, 1'b0);
    end
    n_checks++; if (got.size() != 5) begin n_fail++; $display("FAIL alt_count got %0d want 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_checks++; if (got[i] !== want[i]) begin n_fail++; $display("FAIL alt_tag_%0d got %0d want %0d", i, got[i], want[i]); end
    end
    n_checks++; if (err_align !== 1'b0) begin n_fail++; $display("FAIL alt_err_align got %0b want 0", err_align); end
  endtask

  task automatic test_flush();
    cycle(1'b1, 5'd20, $urandom, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    cycle(1'b1, 5'd21, $urandom, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 5'd22, $urandom, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, $urandom, 1'b0, 1'b1, 1'b0);
    n_checks++; if (wb_if.wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_state got valid=%0b ready=%0b want 0 1", wb_if.wb_valid, issue_ready); end
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b1);
      n_checks++; if (wb_if.wb_valid !== 1'b0 || err_align !== 1'b0) begin
        n_fail++; $display("FAIL flush_shadow_%0d got valid=%0b err_align=%0b want 0 0", i, wb_if.wb_valid, err_align); end
    end
  endtask

  task automatic test_random();
    logic iv, fl;
    for (int c = 0; c < 400; c++) begin
      iv = (m_out < D) && ($urandom_range(0, 1) == 1);
      fl = ($urandom_range(0, 39) == 0);
      cycle(iv, 5'($urandom), $urandom, 1'($urandom_range(0, 1)), fl, 1'b0);
      n_checks++; if (wb_if.wb_valid !== (q_m.size() != 0) || issue_ready !== (m_out < D)) begin
        n_fail++; $display("FAIL rand_ctrl cyc %0d got valid=%0b ready=%0b want %0b %0b",
                           c, wb_if.wb_valid, issue_ready, (q_m.size() != 0), (m_out < D)); end
      if (q_m.size() != 0) begin
        n_checks++; if ({wb_if.wb_rd, wb_if.wb_data} !== q_m[0]) begin
          n_fail++; $display("FAIL rand_head cyc %0d got %h want %h", c, {wb_if.wb_rd, wb_if.wb_data}, q_m[0]); end
      end
      n_checks++; if ({err_align, err_ovf} !== {m_ea, m_eo}) begin
        n_fail++; $display("FAIL rand_errs cyc %0d got %b want %b", c, {err_align, err_ovf}, {m_ea, m_eo}); end
    end
    idle(6, 1'b1);
  endtask

  task automatic test_errors();
    apply_reset();
    cycle(1'b0, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    n_checks++; if (err_align !== 1'b1 || !m_ea) begin n_fail++; $display("FAIL err_align_set got %0b want 1", err_align); end
    idle(3, 1'b0);
    n_checks++; if (err_align !== 1'b1) begin n_fail++; $display("FAIL err_align_sticky got %0b want 1", err_align); end
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'(i), $urandom, 1'b0, 1'b0, 1'b0);
    n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL err_ovf_early got %0b want 0", err_ovf); end
    cycle(1'b1, 5'd4, $urandom, 1'b0, 1'b0, 1'b0);
    n_checks++; if (err_ovf !== 1'b1 || !m_eo) begin n_fail++; $display("FAIL err_ovf_set got %0b want 1", err_ovf); end
    cycle(1'b1, 5'd5, $urandom, 1'b0, 1'b0, 1'b0);
    issue_valid = 1'b0; ftoi_valid = 1'b0; flush = 1'b0;
    #3 rstn = 1'b0;
    #1;
    model_reset();
    n_checks++; if (wb_if.wb_valid !== 1'b0 || issue_ready !== 1'b1 || {err_align, err_ovf} !== 2'b00 ||
                    wb_if.wb_rd !== 5'd0 || wb_if.wb_data !== 32'd0) begin
      n_fail++; $display("FAIL async_reset got valid=%0b ready=%0b errs=%b rd=%0d data=%h want 0 1 00 0 0",
                         wb_if.wb_valid, issue_ready, {err_align, err_ovf}, wb_if.wb_rd, wb_if.wb_data); end
    @(posedge clk); #1 rstn = 1'b1;
    cycle(1'b1, 5'd7, 32'h55, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    n_checks++; if (wb_if.wb_valid !== 1'b1 || wb_if.wb_rd !== 5'd7 || wb_if.wb_data !== 32'h55 || {err_align, err_ovf} !== 2'b00) begin
      n_fail++; $display("FAIL post_reset got v=%0b rd=%0d data=%h errs=%b want 1 7 55 00",
                         wb_if.wb_valid, wb_if.wb_rd, wb_if.wb_data, {err_align, err_ovf}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop_issue();
    test_alternating();
    test_flush();
    test_random();
    test_errors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
